// File: rtl/axi_data_bridge.sv
// Data-side bridge from an SRAM-like req/addr_ok/data_ok interface to AXI.
// Each accepted request becomes one single-beat AXI transaction; only one is in flight at a time.
module axi_data_bridge #(
   parameter logic [3:0]  AXI_ID = 4'd1,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   // Memory-stage request side
   input  logic              req,
   input  logic              wr,
   input  logic [1:0]        size,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              addr_ok,
   output logic              data_ok,
   output logic [31:0]       rdata,
   // AXI read address channel
   output logic [3:0]        arid,
   output logic [ADDR_W-1:0] araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic              arvalid,
   input  logic              arready,
   // AXI read data channel
   input  logic [31:0]       rdata_axi,
   input  logic              rvalid,
   output logic              rready,
   // AXI write address channel
   output logic [3:0]        awid,
   output logic [ADDR_W-1:0] awaddr,
   output logic [7:0]        awlen,
   output logic [2:0]        awsize,
   output logic [1:0]        awburst,
   output logic              awvalid,
   input  logic              awready,
   // AXI write data channel
   output logic [31:0]       wdata_axi,
   output logic [3:0]        wstrb,
   output logic              wlast,
   output logic              wvalid,
   input  logic              wready,
   // AXI write response channel
   input  logic              bvalid,
   output logic              bready
);

   typedef enum logic [2:0] {
      IDLE,
      RD_AR,
      RD_R,
      WR_AW_W,
      WR_B,
      DONE
   } state_e;

   state_e            state_q,   state_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;
   logic [31:0]       wdata_q,   wdata_d;
   logic [1:0]        size_q,    size_d;
   logic              wr_q,      wr_d;
   logic              arvalid_q, arvalid_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q,  wvalid_d;
   logic              rready_q,  rready_d;
   logic              bready_q,  bready_d;
   logic              data_ok_q, data_ok_d;
   logic [31:0]       rdata_q,   rdata_d;

   logic [2:0]        axi_size;
   logic [3:0]        strb;

   // Gated by reset so nothing is accepted while the bridge is held in reset.
   assign addr_ok = reset & req & (state_q == IDLE);

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      size_d    = size_q;
      wr_d      = wr_q;
      arvalid_d = arvalid_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      rready_d  = rready_q;
      bready_d  = bready_q;
      data_ok_d = data_ok_q;
      rdata_d   = rdata_q;

      case (state_q)
         IDLE: begin
            if (addr_ok) begin
               addr_d    = addr;
               wdata_d   = wdata;
               size_d    = size;
               wr_d      = wr;
               arvalid_d = ~wr;
               awvalid_d = wr;
               wvalid_d  = wr;
               state_d   = wr ? WR_AW_W : RD_AR;
            end
         end
         RD_AR: begin
            if (arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_R;
            end
         end
         RD_R: begin
            if (rvalid) begin
               rdata_d   = rdata_axi;
               rready_d  = 1'b0;
               data_ok_d = 1'b1;
               state_d   = DONE;
            end
         end
         WR_AW_W: begin
            // AW and W retire independently; a channel already done keeps its valid low.
            if (awready) awvalid_d = 1'b0;
            if (wready)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WR_B;
            end
         end
         WR_B: begin
            if (bvalid) begin
               bready_d  = 1'b0;
               data_ok_d = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            data_ok_d = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         size_q    <= '0;
         wr_q      <= 1'b0;
         arvalid_q <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         rready_q  <= 1'b0;
         bready_q  <= 1'b0;
         data_ok_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         size_q    <= size_d;
         wr_q      <= wr_d;
         arvalid_q <= arvalid_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         rready_q  <= rready_d;
         bready_q  <= bready_d;
         data_ok_q <= data_ok_d;
         rdata_q   <= rdata_d;
      end
   end

   // Size code 3 is treated as a word access.
   assign axi_size = (size_q == 2'd3) ? 3'd2 : {1'b0, size_q};

   always_comb begin
      case (size_q)
         2'd0:    strb = 4'b0001 << addr_q[1:0];
         2'd1:    strb = addr_q[1] ? 4'b1100 : 4'b0011;
         default: strb = 4'b1111;
      endcase
   end

   assign data_ok   = data_ok_q;
   assign rdata     = rdata_q;

   assign arid      = AXI_ID;
   assign araddr    = addr_q;
   assign arlen     = 8'd0;
   assign arsize    = axi_size;
   assign arburst   = 2'b01;
   assign arvalid   = arvalid_q;
   assign rready    = rready_q;

   assign awid      = AXI_ID;
   assign awaddr    = addr_q;
   assign awlen     = 8'd0;
   assign awsize    = axi_size;
   assign awburst   = 2'b01;
   assign awvalid   = awvalid_q;

   assign wdata_axi = wdata_q;
   assign wstrb     = strb & {4{wr_q}};
   assign wlast     = 1'b1;
   assign wvalid    = wvalid_q;
   assign bready    = bready_q;

endmodule

// File: tb/tb_axi_data_bridge.sv
// Directed bench for axi_data_bridge: reads, writes, split handshakes, stalls, reset and back-to-back.
module tb_axi_data_bridge;

   logic        clk;
   logic        reset;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata_axi;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata_axi;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;

   int n_vec;
   int n_err;

   axi_data_bridge dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .wr        (wr),
      .size      (size),
      .addr      (addr),
      .wdata     (wdata),
      .addr_ok   (addr_ok),
      .data_ok   (data_ok),
      .rdata     (rdata),
      .arid      (arid),
      .araddr    (araddr),
      .arlen     (arlen),
      .arsize    (arsize),
      .arburst   (arburst),
      .arvalid   (arvalid),
      .arready   (arready),
      .rdata_axi (rdata_axi),
      .rvalid    (rvalid),
      .rready    (rready),
      .awid      (awid),
      .awaddr    (awaddr),
      .awlen     (awlen),
      .awsize    (awsize),
      .awburst   (awburst),
      .awvalid   (awvalid),
      .awready   (awready),
      .wdata_axi (wdata_axi),
      .wstrb     (wstrb),
      .wlast     (wlast),
      .wvalid    (wvalid),
      .wready    (wready),
      .bvalid    (bvalid),
      .bready    (bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Move to 1 time unit after the next rising edge; inputs are driven here.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Move to the middle of the cycle, away from the edge, to sample outputs.
   task automatic half();
      #4;
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      reset     = 1'b0;
      req       = 1'b0;
      wr        = 1'b0;
      size      = 2'd0;
      addr      = '0;
      wdata     = '0;
      arready   = 1'b0;
      rdata_axi = '0;
      rvalid    = 1'b0;
      awready   = 1'b0;
      wready    = 1'b0;
      bvalid    = 1'b0;

      // ---------------- reset state ----------------
      cyc();
      cyc();
      half();
      chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
      chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
      chk("rst_wvalid",  {31'd0, wvalid},  32'd0);
      chk("rst_rready",  {31'd0, rready},  32'd0);
      chk("rst_bready",  {31'd0, bready},  32'd0);
      chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
      chk("rst_rdata",   rdata,            32'd0);
      chk("tie_arid",    {28'd0, arid},    32'd1);
      chk("tie_awid",    {28'd0, awid},    32'd1);
      chk("tie_arlen",   {24'd0, arlen},   32'd0);
      chk("tie_arburst", {30'd0, arburst}, 32'd1);
      chk("tie_awburst", {30'd0, awburst}, 32'd1);
      cyc();
      reset = 1'b1;

      // ---------------- read word, all ready ----------------
      req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h1FC0_0010;
      arready = 1'b1; rvalid = 1'b1; rdata_axi = 32'hDEAD_BEEF;
      half();
      chk("rd_c0_addr_ok", {31'd0, addr_ok}, 32'd1);
      chk("rd_c0_data_ok", {31'd0, data_ok}, 32'd0);
      cyc();
      req = 1'b0;
      half();
      chk("rd_c1_arvalid", {31'd0, arvalid}, 32'd1);
      chk("rd_c1_araddr",  araddr,           32'h1FC0_0010);
      chk("rd_c1_arsize",  {29'd0, arsize},  32'd2);
      chk("rd_c1_data_ok", {31'd0, data_ok}, 32'd0);
      cyc();
      half();
      chk("rd_c2_rready",  {31'd0, rready},  32'd1);
      chk("rd_c2_arvalid", {31'd0, arvalid}, 32'd0);
      chk("rd_c2_data_ok", {31'd0, data_ok}, 32'd0);
      cyc();
      half();
      chk("rd_c3_data_ok", {31'd0, data_ok}, 32'd1);
      chk("rd_c3_rdata",   rdata,            32'hDEAD_BEEF);
      chk("rd_c3_rready",  {31'd0, rready},  32'd0);
      cyc();
      arready = 1'b0; rvalid = 1'b0;
      half();
      chk("rd_c4_data_ok", {31'd0, data_ok}, 32'd0);
      cyc();

      // ---------------- write byte, bvalid one cycle late ----------------
      req = 1'b1; wr = 1'b1; size = 2'd0; addr = 32'h0000_0103; wdata = 32'hAA00_0000;
      awready = 1'b1; wready = 1'b1;
      half();
      chk("wb_c0_addr_ok", {31'd0, addr_ok}, 32'd1);
      cyc();
      req = 1'b0;
      half();
      chk("wb_c1_awvalid", {31'd0, awvalid},  32'd1);
      chk("wb_c1_wvalid",  {31'd0, wvalid},   32'd1);
      chk("wb_c1_wstrb",   {28'd0, wstrb},    32'h8);
      chk("wb_c1_awsize",  {29'd0, awsize},   32'd0);
      chk("wb_c1_wlast",   {31'd0, wlast},    32'd1);
      chk("wb_c1_awaddr",  awaddr,            32'h0000_0103);
      chk("wb_c1_wdata",   wdata_axi,         32'hAA00_0000);
      chk("wb_c1_bready",  {31'd0, bready},   32'd0);
      cyc();
      awready = 1'b0; wready = 1'b0;
      half();
      chk("wb_c2_awvalid", {31'd0, awvalid}, 32'd0);
      chk("wb_c2_wvalid",  {31'd0, wvalid},  32'd0);
      chk("wb_c2_bready",  {31'd0, bready},  32'd1);
      chk("wb_c2_data_ok", {31'd0, data_ok}, 32'd0);
      cyc();
      bvalid = 1'b1;
      half();
      chk("wb_c3_bready",  {31'd0, bready},  32'd1);
      chk("wb_c3_data_ok", {31'd0, data_ok}, 32'd0);
      cyc();
      bvalid = 1'b0;
      half();
      chk("wb_c4_data_ok", {31'd0, data_ok}, 32'd1);
      chk("wb_c4_bready",  {31'd0, bready},  32'd0);
      cyc();
      half();
      chk("wb_c5_data_ok", {31'd0, data_ok}, 32'd0);
      cyc();

      // ---------------- write word, AW early, W late ----------------
      req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h0000_0200; wdata = 32'h1234_5678;
      awready = 1'b1; wready = 1'b0;
      half();
      chk("ws_c0_addr_ok", {31'd0, addr_ok}, 32'd1);
      cyc();
      req = 1'b0;
      half();
      chk("ws_c1_awvalid", {31'd0, awvalid}, 32'd1);
      chk("ws_c1_wvalid",  {31'd0, wvalid},  32'd1);
      chk("ws_c1_wstrb",   {28'd0, wstrb},   32'hF);
      cyc();
      awready = 1'b0;
      half();
      chk("ws_c2_awvalid", {31'd0, awvalid}, 32'd0);
      chk("ws_c2_wvalid",  {31'd0, wvalid},  32'd1);
      chk("ws_c2_bready",  {31'd0, bready},  32'd0);
      cyc();
      half();
      chk("ws_c3_wvalid",  {31'd0, wvalid},  32'd1);
      chk("ws_c3_bready",  {31'd0, bready},  32'd0);
      cyc();
      wready = 1'b1;
      half();
      chk("ws_c4_wvalid",  {31'd0, wvalid},  32'd1);
      chk("ws_c4_bready",  {31'd0, bready},  32'd0);
      chk("ws_c4_wdata",   wdata_axi,        32'h1234_5678);
      cyc();
      wready = 1'b0; bvalid = 1'b1;
      half();
      chk("ws_c5_wvalid",  {31'd0, wvalid},  32'd0);
      chk("ws_c5_bready",  {31'd0, bready},  32'd1);
      chk("ws_c5_data_ok", {31'd0, data_ok}, 32'd0);
      cyc();
      bvalid = 1'b0;
      half();
      chk("ws_c6_data_ok", {31'd0, data_ok}, 32'd1);
      cyc();
      half();
      chk("ws_c7_data_ok", {31'd0, data_ok}, 32'd0);
      cyc();

      // ---------------- read, size 3, AR and R stalls, req held ----------------
      req = 1'b1; wr = 1'b0; size = 2'd3; addr = 32'h8000_0044;
      arready = 1'b0; rvalid = 1'b0; rdata_axi = 32'hCAFE_F00D;
      half();
      chk("st_c0_addr_ok", {31'd0, addr_ok}, 32'd1);
      cyc();
      addr = 32'h0000_0000;
      for (int i = 1; i <= 5; i++) begin
         half();
         chk("st_ar_arvalid", {31'd0, arvalid}, 32'd1);
         chk("st_ar_araddr",  araddr,           32'h8000_0044);
         chk("st_ar_arsize",  {29'd0, arsize},  32'd2);
         chk("st_ar_addr_ok", {31'd0, addr_ok}, 32'd0);
         cyc();
      end
      arready = 1'b1;
      half();
      chk("st_c6_arvalid", {31'd0, arvalid}, 32'd1);
      chk("st_c6_araddr",  araddr,           32'h8000_0044);
      cyc();
      arready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         half();
         chk("st_r_rready",  {31'd0, rready},  32'd1);
         chk("st_r_arvalid", {31'd0, arvalid}, 32'd0);
         chk("st_r_data_ok", {31'd0, data_ok}, 32'd0);
         chk("st_r_addr_ok", {31'd0, addr_ok}, 32'd0);
         cyc();
      end
      rvalid = 1'b1;
      half();
      chk("st_c10_data_ok", {31'd0, data_ok}, 32'd0);
      cyc();
      rvalid = 1'b0;
      half();
      chk("st_c11_data_ok", {31'd0, data_ok}, 32'd1);
      chk("st_c11_rdata",   rdata,            32'hCAFE_F00D);
      chk("st_c11_addr_ok", {31'd0, addr_ok}, 32'd0);
      cyc();
      req = 1'b0;
      half();
      chk("st_c12_data_ok", {31'd0, data_ok}, 32'd0);
      cyc();

      // ---------------- reset while in RD_R ----------------
      req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_0300;
      arready = 1'b1; rvalid = 1'b0; rdata_axi = 32'h7777_7777;
      half();
      chk("rr_c0_addr_ok", {31'd0, addr_ok}, 32'd1);
      cyc();
      req = 1'b0;
      cyc();
      half();
      chk("rr_c2_rready",  {31'd0, rready},  32'd1);
      reset = 1'b0;
      rvalid = 1'b1;
      #1;
      chk("rr_async_arvalid", {31'd0, arvalid}, 32'd0);
      chk("rr_async_rready",  {31'd0, rready},  32'd0);
      chk("rr_async_data_ok", {31'd0, data_ok}, 32'd0);
      chk("rr_async_rdata",   rdata,            32'd0);
      cyc();
      reset = 1'b1; rvalid = 1'b0;
      req = 1'b1; wr = 1'b0; size = 2'd1; addr = 32'h0000_0400;
      rdata_axi = 32'h55AA_55AA;
      half();
      chk("rr_new_addr_ok", {31'd0, addr_ok}, 32'd1);
      chk("rr_new_data_ok", {31'd0, data_ok}, 32'd0);
      cyc();
      req = 1'b0; rvalid = 1'b1;
      half();
      chk("rr_n1_arsize",  {29'd0, arsize},  32'd1);
      chk("rr_n1_araddr",  araddr,           32'h0000_0400);
      chk("rr_n1_data_ok", {31'd0, data_ok}, 32'd0);
      cyc();
      half();
      chk("rr_n2_data_ok", {31'd0, data_ok}, 32'd0);
      cyc();
      half();
      chk("rr_n3_data_ok", {31'd0, data_ok}, 32'd1);
      chk("rr_n3_rdata",   rdata,            32'h55AA_55AA);
      cyc();
      arready = 1'b0; rvalid = 1'b0;
      half();
      chk("rr_n4_data_ok", {31'd0, data_ok}, 32'd0);
      cyc();

      // ---------------- halfword write then back-to-back read ----------------
      req = 1'b1; wr = 1'b1; size = 2'd1; addr = 32'h0000_1002; wdata = 32'hBEEF_0000;
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
      half();
      chk("bb_c0_addr_ok", {31'd0, addr_ok}, 32'd1);
      cyc();
      wr = 1'b0; size = 2'd2; addr = 32'h0000_2000;
      arready = 1'b1; rvalid = 1'b1; rdata_axi = 32'h0BAD_F00D;
      half();
      chk("bb_c1_wstrb",   {28'd0, wstrb},   32'hC);
      chk("bb_c1_awsize",  {29'd0, awsize},  32'd1);
      chk("bb_c1_awaddr",  awaddr,           32'h0000_1002);
      chk("bb_c1_addr_ok", {31'd0, addr_ok}, 32'd0);
      cyc();
      half();
      chk("bb_c2_bready",  {31'd0, bready},  32'd1);
      chk("bb_c2_addr_ok", {31'd0, addr_ok}, 32'd0);
      cyc();
      half();
      chk("bb_c3_data_ok", {31'd0, data_ok}, 32'd1);
      chk("bb_c3_addr_ok", {31'd0, addr_ok}, 32'd0);
      cyc();
      half();
      chk("bb_c4_addr_ok", {31'd0, addr_ok}, 32'd1);
      chk("bb_c4_data_ok", {31'd0, data_ok}, 32'd0);
      cyc();
      req = 1'b0;
      half();
      chk("bb_c5_arvalid", {31'd0, arvalid}, 32'd1);
      chk("bb_c5_araddr",  araddr,           32'h0000_2000);
      cyc();
      cyc();
      half();
      chk("bb_c7_data_ok", {31'd0, data_ok}, 32'd1);
      chk("bb_c7_rdata",   rdata,            32'h0BAD_F00D);
      cyc();
      half();
      chk("bb_c8_data_ok", {31'd0, data_ok}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axi_data_bridge.md
Name: axi_data_bridge

Overview:
- Sits directly downstream of the MMU on the data side.
- Takes physical addresses from the MMU plus an SRAM-like request (req/addr_ok/data_ok) from the memory stage.
- Converts each request into exactly one single-beat AXI read or write transaction.
- Blocking, one outstanding transaction: a new request is accepted only after the previous one completes.

Parameters:
- AXI_ID, 4'd1, constant driven on arid/awid.
- ADDR_W, 32, width of the physical address.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  1  request valid from memory stage.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- addr  in  ADDR_W  physical address from the MMU.
- wdata  in  32  write data, byte lanes already aligned by the requester.
- addr_ok  out  1  request accepted this cycle.
- data_ok  out  1  one-cycle pulse: transaction complete.
- rdata  out  32  read data, valid while data_ok = 1.
- arid/araddr/arsize/arvalid  out  4/ADDR_W/3/1  AXI read address channel; arlen = 0 and arburst = INCR are tied off.
- arready  in  1
- rdata_axi  in  32  AXI read data.
- rvalid  in  1
- rready  out  1
- awid/awaddr/awsize/awvalid  out  4/ADDR_W/3/1  AXI write address channel; awlen = 0 and awburst = INCR are tied off.
- awready  in  1
- wdata_axi/wstrb/wlast/wvalid  out  32/4/1/1  AXI write data channel.
- wready  in  1
- bvalid  in  1
- bready  out  1

Behaviour:
- States: IDLE, RD_AR, RD_R, WR_AW_W, WR_B, DONE.
- Reset (reset = 0, asynchronous):
  - state = IDLE.
  - arvalid, awvalid, wvalid, rready, bready, data_ok = 0.
  - rdata = 0; latched address/data/size = 0.
  - An in-flight transaction is abandoned; no data_ok is produced for it.
- IDLE:
  - addr_ok = req & (state == IDLE), combinational; it is 0 in every other state.
  - On addr_ok, latch addr, wdata, size and wr.
  - Next state is RD_AR if wr = 0, WR_AW_W if wr = 1.
- RD_AR:
  - arvalid = 1; araddr = latched addr, unmodified; arsize = {1'b0, size}, with size 3 mapped to 3'd2.
  - Leave for RD_R on the cycle arvalid & arready.
  - arvalid stays high until that handshake; address and size are held stable.
- RD_R:
  - rready = 1.
  - On rvalid, capture rdata_axi into rdata and go to DONE.
- WR_AW_W:
  - awvalid and wvalid both rise on entry; wlast = 1.
  - Each valid drops independently on the cycle after its own handshake (awready or wready).
  - Go to WR_B when both handshakes have completed; AW and W may complete in the same cycle or in either order.
  - wstrb for size 0: 4'b0001 << addr[1:0].
  - wstrb for size 1: addr[1] ? 4'b1100 : 4'b0011.
  - wstrb for size 2 or 3: 4'b1111.
- WR_B:
  - bready = 1.
  - On bvalid, go to DONE.
- DONE:
  - data_ok = 1 for exactly one cycle; rdata holds the captured value (don't-care for writes).
  - Next state IDLE. A req present in the DONE cycle is not accepted; it waits for IDLE.
- Latency with all AXI ready/valid signals immediate: addr_ok at cycle 0, AR handshake at cycle 1, R handshake at cycle 2, data_ok at cycle 3. Back-to-back requests are accepted every 4 cycles.
- rresp/bresp are ignored; an error response completes like OKAY.
- No combinational path from any AXI input to any AXI output.
- req deasserted while not in IDLE has no effect.

Test Plan:
- Read, word: req = 1, wr = 0, size = 2, addr = 0x1FC00010; arready and rvalid tied high; rdata_axi = 0xDEADBEEF -> addr_ok at cycle 0, araddr = 0x1FC00010 and arsize = 2 at cycle 1, data_ok = 1 and rdata = 0xDEADBEEF at cycle 3 only.
- Write, byte: wr = 1, size = 0, addr = 0x00000103, wdata = 0xAA000000 -> wstrb = 4'b1000, awsize = 0, wlast = 1; data_ok one cycle after the bvalid handshake.
- Write, split handshake: awready = 1 at cycle 1, wready held low until cycle 4 -> awvalid drops at cycle 2, wvalid held until cycle 4 inclusive; bready rises only after both handshakes; exactly one data_ok.
- Read, stalls: arready held low 5 cycles, then rvalid delayed 3 cycles -> arvalid held stable with constant araddr; addr_ok = 0 throughout; data_ok after R.
- Reset mid-op: reset = 0 asserted while in RD_R -> arvalid, rready and data_ok go to 0 immediately (before the next clock edge); after release, a new req gets addr_ok in its first cycle; no stale data_ok.
- Halfword plus back-to-back: size = 1 write at addr 0x...2 (wstrb 4'b1100), then a read with req held high -> the second addr_ok comes exactly one cycle after the first data_ok.
